// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal sequencer.
//   state_t : sequencer FSM encoding
//   pedal_t : pedal select (PED_R / PED_L)
//   ERR_*   : err_code values
package pedal_pkg;

  localparam int unsigned LVL_W = 2;  // speed level width
  localparam int unsigned CNT_W = 8;  // press counter width
  localparam int unsigned CYC_W = 4;  // pulse/settle cycle counter width
  localparam int unsigned ERR_W = 2;  // error code width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    PRESS  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef enum logic {
    PED_R = 1'b0,
    PED_L = 1'b1
  } pedal_t;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [ERR_W-1:0] ERR_ONEHOT  = 2'b10;

endpackage

// File: rtl/pedal_seq_driver_if.sv
// Request/response interface between a controller and pedal_seq_driver.
//   start, target, abort : controller -> driver
//   busy, done, err, err_code, press_cnt : driver -> controller
interface pedal_seq_driver_if;
  import pedal_pkg::*;

  logic             start;
  logic [LVL_W-1:0] target;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [ERR_W-1:0] err_code;
  logic [CNT_W-1:0] press_cnt;

  modport master (
    output start, target, abort,
    input  busy, done, err, err_code, press_cnt
  );

  modport slave (
    input  start, target, abort,
    output busy, done, err, err_code, press_cnt
  );

endinterface

// File: rtl/speed_onehot_dec.sv
// Combinational one-hot decode of the four speed indicator lines.
//   speed   : {speed_3, speed_2, speed_1, speed_0}
//   level_c : decoded level 0..3 (0 when invalid)
//   valid_c : exactly one line high
module speed_onehot_dec
  import pedal_pkg::*;
(
  input  logic [3:0]       speed,
  output logic [LVL_W-1:0] level_c,
  output logic             valid_c
);

  always_comb begin
    level_c = '0;
    valid_c = 1'b0;
    case (speed)
      4'b0001: begin level_c = 2'd0; valid_c = 1'b1; end
      4'b0010: begin level_c = 2'd1; valid_c = 1'b1; end
      4'b0100: begin level_c = 2'd2; valid_c = 1'b1; end
      4'b1000: begin level_c = 2'd3; valid_c = 1'b1; end
      default: begin level_c = '0;   valid_c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/pedal_seq_driver.sv
// Pedal sequencer: presses L/R on the speed FSM until the requested level
// is seen on its one-hot speed outputs, or reports timeout / bad vector.
//   clk, reset (async, active-low)
//   req              : request/response interface (slave side)
//   speed_0..speed_3 : one-hot speed indicators from the FSM
//   L, R             : registered pedal lines, never high together
module pedal_seq_driver
  import pedal_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 1,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_PRESS  = 12
) (
  input  logic                clk,
  input  logic                reset,
  pedal_seq_driver_if.slave   req,
  input  logic                speed_0,
  input  logic                speed_1,
  input  logic                speed_2,
  input  logic                speed_3,
  output logic                L,
  output logic                R
);

  state_t           state_q, state_d;
  pedal_t           last_q, last_d;
  pedal_t           ped_c;
  logic [LVL_W-1:0] tgt_q, tgt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [ERR_W-1:0] code_q, code_d;
  logic             l_q, l_d, r_q, r_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LVL_W-1:0] level_c;
  logic             valid_c;

  speed_onehot_dec u_dec (
    .speed   ({speed_3, speed_2, speed_1, speed_0}),
    .level_c (level_c),
    .valid_c (valid_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= PED_R;
      tgt_q   <= '0;
      cyc_q   <= '0;
      pcnt_q  <= '0;
      code_q  <= ERR_NONE;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
      cyc_q   <= cyc_d;
      pcnt_q  <= pcnt_d;
      code_q  <= code_d;
      l_q     <= l_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state; output values are computed for the state being entered
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tgt_d   = tgt_q;
    cyc_d   = cyc_q;
    pcnt_d  = pcnt_q;
    code_d  = code_q;
    l_d     = 1'b0;
    r_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Below target: alternate pedals to speed up; above: repeat to slow down
    ped_c   = (level_c < tgt_q) ? ((last_q == PED_L) ? PED_R : PED_L) : last_q;

    if (req.abort) begin
      // Also blocks a same-cycle start in IDLE
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req.start) begin
            state_d = CHECK;
            tgt_d   = req.target;
            pcnt_d  = '0;
            code_d  = ERR_NONE;
            busy_d  = 1'b1;
          end
        end
        CHECK: begin
          if (!valid_c) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = ERR_ONEHOT;
          end else if (level_c == tgt_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (pcnt_q == CNT_W'(MAX_PRESS)) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
          end else begin
            state_d = PRESS;
            last_d  = ped_c;
            pcnt_d  = pcnt_q + 1'b1;
            cyc_d   = CYC_W'(PULSE_CYC - 1);
            l_d     = (ped_c == PED_L);
            r_d     = (ped_c == PED_R);
          end
        end
        PRESS: begin
          if (cyc_q == '0) begin
            state_d = SETTLE;
            cyc_d   = CYC_W'(SETTLE_CYC - 1);
          end else begin
            cyc_d = cyc_q - 1'b1;
            l_d   = l_q;
            r_d   = r_q;
          end
        end
        SETTLE: begin
          if (cyc_q == '0) begin
            state_d = CHECK;
          end else begin
            cyc_d = cyc_q - 1'b1;
          end
        end
        DONE, ERR: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign L             = l_q;
  assign R             = r_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign req.err_code  = code_q;
  assign req.press_cnt = pcnt_q;

endmodule

// File: tb/tb_pedal_seq_driver.sv
// Directed bench for pedal_seq_driver with a behavioural speed-FSM plant:
// an alternating press raises the level (saturate 3), a repeated pedal
// lowers it (floor 0).
module tb_pedal_seq_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       L, R;
  logic       speed_0, speed_1, speed_2, speed_3;

  logic [1:0] plant_lvl;
  logic       plant_last;     // 1 = L, 0 = R
  logic       load;
  logic [1:0] load_val;
  logic       stuck;
  logic       force_bad;
  logic [3:0] spd;

  int         checks = 0;
  int         errors = 0;
  int         pn = 0;
  int         r_seen = 0;
  int         done_seen = 0;
  int         err_seen = 0;
  int         overlap = 0;
  logic [15:0] plog = '0;

  pedal_seq_driver_if bus ();

  pedal_seq_driver #(
    .PULSE_CYC (1),
    .SETTLE_CYC(1),
    .MAX_PRESS (12)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .req     (bus),
    .speed_0 (speed_0),
    .speed_1 (speed_1),
    .speed_2 (speed_2),
    .speed_3 (speed_3),
    .L       (L),
    .R       (R)
  );

  always #5 clk = ~clk;

  assign spd     = force_bad ? 4'b0110 : (4'b0001 << plant_lvl);
  assign speed_0 = spd[0];
  assign speed_1 = spd[1];
  assign speed_2 = spd[2];
  assign speed_3 = spd[3];

  // Plant model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plant_lvl  <= 2'd0;
      plant_last <= 1'b0;
    end else if (load) begin
      plant_lvl <= load_val;
    end else if (L || R) begin
      if (!stuck) begin
        if (L != plant_last) plant_lvl <= (plant_lvl == 2'd3) ? 2'd3 : plant_lvl + 2'd1;
        else                 plant_lvl <= (plant_lvl == 2'd0) ? 2'd0 : plant_lvl - 2'd1;
      end
      plant_last <= L;
    end
  end

  // Pedal / response monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (L && R) overlap <= overlap + 1;
      if (L || R) begin
        plog <= {plog[14:0], L};
        pn   <= pn + 1;
      end
      if (R)        r_seen    <= r_seen + 1;
      if (bus.done) done_seen <= done_seen + 1;
      if (bus.err)  err_seen  <= err_seen + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_lvl(input logic [1:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Issues start and waits (bounded) for done or err; cyc counts cycles after start
  task automatic request(input logic [1:0] tgt, input int max_cyc, output int cyc);
    bus.start  = 1'b1;
    bus.target = tgt;
    @(negedge clk);
    bus.start  = 1'b0;
    cyc = 1;
    while (!(bus.done || bus.err) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_L"},        32'(L), 32'd0);
    check({tag, "_R"},        32'(R), 32'd0);
    check({tag, "_busy"},     32'(bus.busy), 32'd0);
    check({tag, "_done"},     32'(bus.done), 32'd0);
    check({tag, "_err"},      32'(bus.err), 32'd0);
    check({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
    check({tag, "_pcnt"},     32'(bus.press_cnt), 32'd0);
  endtask

  initial begin
    int cyc;
    int pn0, r0, d0, e0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.target = 2'd0;
    bus.abort  = 1'b0;
    load       = 1'b0;
    load_val   = 2'd0;
    stuck      = 1'b0;
    force_bad  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: 0 -> 3, presses L R L
    load_lvl(2'd0);
    pn0 = pn;
    request(2'd3, 60, cyc);
    check("s1_latency", 32'(cyc), 32'd11);
    check("s1_done",    32'(bus.done), 32'd1);
    check("s1_err",     32'(bus.err), 32'd0);
    check("s1_busy",    32'(bus.busy), 32'd1);
    check("s1_pcnt",    32'(bus.press_cnt), 32'd3);
    check("s1_npress",  32'(pn - pn0), 32'd3);
    check("s1_seq",     32'(plog[2:0]), 32'(3'b101));
    @(negedge clk);
    check("s1_done_drop", 32'(bus.done), 32'd0);
    check("s1_busy_drop", 32'(bus.busy), 32'd0);
    check("s1_pcnt_hold", 32'(bus.press_cnt), 32'd3);

    // Scenario 2: 2 -> 0 with last pedal L, presses L L
    load_lvl(2'd2);
    r0 = r_seen;
    request(2'd0, 60, cyc);
    check("s2_latency", 32'(cyc), 32'd8);
    check("s2_done",    32'(bus.done), 32'd1);
    check("s2_pcnt",    32'(bus.press_cnt), 32'd2);
    check("s2_seq",     32'(plog[1:0]), 32'(2'b11));
    check("s2_no_R",    32'(r_seen - r0), 32'd0);
    @(negedge clk);

    // Scenario 3: already at target
    load_lvl(2'd1);
    pn0 = pn;
    request(2'd1, 60, cyc);
    check("s3_latency", 32'(cyc), 32'd2);
    check("s3_done",    32'(bus.done), 32'd1);
    check("s3_pcnt",    32'(bus.press_cnt), 32'd0);
    check("s3_npress",  32'(pn - pn0), 32'd0);
    @(negedge clk);

    // Scenario 4: plant stuck at 0 -> timeout after 12 presses
    stuck = 1'b1;
    load_lvl(2'd0);
    pn0 = pn;
    request(2'd2, 80, cyc);
    check("s4_latency", 32'(cyc), 32'd38);
    check("s4_err",     32'(bus.err), 32'd1);
    check("s4_done",    32'(bus.done), 32'd0);
    check("s4_code",    32'(bus.err_code), 32'(2'b01));
    check("s4_pcnt",    32'(bus.press_cnt), 32'd12);
    check("s4_npress",  32'(pn - pn0), 32'd12);
    @(negedge clk);
    check("s4_err_drop",  32'(bus.err), 32'd0);
    check("s4_code_hold", 32'(bus.err_code), 32'(2'b01));
    check("s4_busy_drop", 32'(bus.busy), 32'd0);
    stuck = 1'b0;

    // Scenario 5: speed vector 0110
    force_bad = 1'b1;
    request(2'd0, 20, cyc);
    check("s5_latency", 32'(cyc), 32'd2);
    check("s5_err",     32'(bus.err), 32'd1);
    check("s5_code",    32'(bus.err_code), 32'(2'b10));
    check("s5_pcnt",    32'(bus.press_cnt), 32'd0);
    @(negedge clk);
    force_bad = 1'b0;

    // Scenario 6a: abort during the second press
    load_lvl(2'd0);
    d0 = done_seen;
    e0 = err_seen;
    bus.start  = 1'b1;
    bus.target = 2'd3;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    check("s6_press2_L",    32'(L), 32'd1);
    check("s6_press2_pcnt", 32'(bus.press_cnt), 32'd2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("s6_abort_L",    32'(L), 32'd0);
    check("s6_abort_R",    32'(R), 32'd0);
    check("s6_abort_busy", 32'(bus.busy), 32'd0);
    check("s6_abort_pcnt", 32'(bus.press_cnt), 32'd2);
    repeat (4) @(negedge clk);
    check("s6_no_done", 32'(done_seen - d0), 32'd0);
    check("s6_no_err",  32'(err_seen - e0), 32'd0);
    check("s6_idle",    32'(bus.busy), 32'd0);

    // Scenario 6b: async reset mid-press (plant at 2, last L -> press R)
    bus.start  = 1'b1;
    bus.target = 2'd3;
    @(negedge clk);
    bus.start  = 1'b0;
    @(negedge clk);
    check("s6_rst_pre_R", 32'(R), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_now_L", 32'(L), 32'd0);
    check("s6_rst_now_R", 32'(R), 32'd0);
    check("s6_rst_now_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("s6_post");

    // last pedal back to R after reset: 0 -> 1 takes one L press
    request(2'd1, 30, cyc);
    check("s6_lastR_latency", 32'(cyc), 32'd5);
    check("s6_lastR_done",    32'(bus.done), 32'd1);
    check("s6_lastR_pedal",   32'(plog[0]), 32'd1);
    @(negedge clk);

    check("no_LR_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
